// File: rtl/nfu_pkg.sv
// Shared definitions for the NFU tile scheduler: FSM states and parameter defaults.
package nfu_pkg;

    localparam int N_DEF      = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int PIPE_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/nfu_wr_tracker.sv
// Follows every issued read through the multiply-add pipeline so the final
// sum of an output tile is written exactly PIPE enabled cycles after its last read.
module nfu_wr_tracker
    import nfu_pkg::*;
#(
    parameter int PIPE   = PIPE_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_push_vld,
    input  logic              i_push_last,
    input  logic [ADDR_W-1:0] i_push_out,
    output logic              o_tail_wr,
    output logic [ADDR_W-1:0] o_tail_out,
    output logic              o_pend
);

    logic [PIPE-1:0]   r_vld;
    logic [PIPE-1:0]   r_last;
    logic [ADDR_W-1:0] r_out [PIPE];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int i = 0; i < PIPE; i++) begin
                r_out[i] <= '0;
            end
        end else if (i_en) begin
            r_vld[0]  <= i_push_vld;
            r_last[0] <= i_push_last;
            r_out[0]  <= i_push_out;
            for (int i = 1; i < PIPE; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_last[i] <= r_last[i-1];
                r_out[i]  <= r_out[i-1];
            end
        end
    end

    // Entries still in flight once the tail has been consumed this cycle.
    always_comb begin
        o_pend = 1'b0;
        for (int i = 0; i < PIPE - 1; i++) begin
            o_pend = o_pend | r_vld[i];
        end
    end

    assign o_tail_wr  = r_vld[PIPE-1] & r_last[PIPE-1];
    assign o_tail_out = r_out[PIPE-1];

endmodule

// File: rtl/nfu_tile_sched.sv
// NFU tile scheduler: walks Ti input tiles per output tile, drives the shared
// buffer read strobe/addresses and the NBout write of each completed sum.
module nfu_tile_sched
    import nfu_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PIPE   = PIPE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_num_in,
    input  logic [ADDR_W-1:0] i_num_out,
    input  logic              i_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd,
    output logic [ADDR_W-1:0] o_nbin_addr,
    output logic [ADDR_W-1:0] o_sb_addr,
    output logic [ADDR_W-1:0] o_nbout_rd_addr,
    output logic              o_acc_first,
    output logic              o_nbout_wr,
    output logic [ADDR_W-1:0] o_nbout_wr_addr
);

    if (N < 1 || ADDR_W < 1 || PIPE < 1) begin : g_param_chk
        $error("nfu_tile_sched: N, ADDR_W and PIPE must all be at least 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ti;
    logic [ADDR_W-1:0] r_to;
    logic [ADDR_W-1:0] r_in;
    logic [ADDR_W-1:0] r_out;
    logic [ADDR_W-1:0] r_sb;
    logic              r_rd;
    logic              r_acc_first;
    logic              r_wr;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_nbin_addr;
    logic [ADDR_W-1:0] r_sb_addr;
    logic [ADDR_W-1:0] r_nbout_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;

    logic              w_en;
    logic              w_issue;
    logic              w_in_last;
    logic              w_out_last;
    logic              w_tail_wr;
    logic              w_pend;
    logic [ADDR_W-1:0] w_tail_out;

    // IDLE never freezes, so a start arriving together with a stall is still taken.
    assign w_en       = ~i_stall | (r_state == ST_IDLE);
    assign w_issue    = (r_state == ST_RUN);
    assign w_in_last  = (r_in == r_ti - ADDR_W'(1));
    assign w_out_last = (r_out == r_to - ADDR_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_num_in != '0 && i_num_out != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_in_last && w_out_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_pend) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_ti            <= '0;
            r_to            <= '0;
            r_in            <= '0;
            r_out           <= '0;
            r_sb            <= '0;
            r_rd            <= 1'b0;
            r_acc_first     <= 1'b0;
            r_wr            <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_nbin_addr     <= '0;
            r_sb_addr       <= '0;
            r_nbout_rd_addr <= '0;
            r_wr_addr       <= '0;
        end else if (w_en) begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE) | (r_state == ST_DONE);
            r_done      <= (r_state == ST_DONE);
            r_rd        <= w_issue;
            r_acc_first <= w_issue & (r_in == '0);
            r_wr        <= w_tail_wr;
            r_wr_addr   <= w_tail_out;
            if (r_state == ST_IDLE && i_start) begin
                r_ti  <= i_num_in;
                r_to  <= i_num_out;
                r_in  <= '0;
                r_out <= '0;
                r_sb  <= '0;
            end
            // Addresses are registered at issue and held through any stall.
            if (w_issue) begin
                r_nbin_addr     <= r_in;
                r_sb_addr       <= r_sb;
                r_nbout_rd_addr <= r_out;
                r_sb            <= r_sb + ADDR_W'(1);
                if (w_in_last) begin
                    r_in  <= '0;
                    r_out <= r_out + ADDR_W'(1);
                end else begin
                    r_in  <= r_in + ADDR_W'(1);
                end
            end
        end
    end

    nfu_wr_tracker #(
        .PIPE   (PIPE),
        .ADDR_W (ADDR_W)
    ) u_wr_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_en),
        .i_push_vld  (w_issue),
        .i_push_last (w_in_last),
        .i_push_out  (r_out),
        .o_tail_wr   (w_tail_wr),
        .o_tail_out  (w_tail_out),
        .o_pend      (w_pend)
    );

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_rd            = r_rd & ~i_stall;
    assign o_acc_first     = r_acc_first & ~i_stall;
    assign o_nbout_wr      = r_wr & ~i_stall;
    assign o_nbin_addr     = r_nbin_addr;
    assign o_sb_addr       = r_sb_addr;
    assign o_nbout_rd_addr = r_nbout_rd_addr;
    assign o_nbout_wr_addr = r_wr_addr;

endmodule

// File: doc/nfu_tile_sched.md
NFU_TILE_SCHED -- requirements
Module: nfu_tile_sched

Interface
REQ-001 Parameter N, default 16: datapath word width; carried for the package, no effect on control timing.
REQ-002 Parameter ADDR_W, default 8: width of every buffer address and tile-count port.
REQ-003 Parameter PIPE, default 3: cycles from a buffer read strobe to the matching multiply-add result being writable.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_start  in  1  one-cycle job start; i_num_in and i_num_out sampled on the same edge.
REQ-007 i_num_in  in  ADDR_W  input tiles accumulated per output tile (Ti).
REQ-008 i_num_out  in  ADDR_W  output tiles in the job (To).
REQ-009 i_stall  in  1  buffer back-pressure; freezes the whole block while high.
REQ-010 o_busy  out  1  high from the cycle after an accepted start until o_done.
REQ-011 o_done  out  1  one-cycle pulse when the job completes.
REQ-012 o_rd  out  1  read strobe, common to NBin, SB and NBout.
REQ-013 o_nbin_addr  out  ADDR_W  NBin read address.
REQ-014 o_sb_addr  out  ADDR_W  SB read address.
REQ-015 o_nbout_rd_addr  out  ADDR_W  NBout partial-sum read address.
REQ-016 o_acc_first  out  1  qualifies o_rd: first input tile, so the datapath adds zero instead of the NBout partial sum.
REQ-017 o_nbout_wr  out  1  NBout write strobe for a final sum.
REQ-018 o_nbout_wr_addr  out  ADDR_W  NBout write address.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE transitions on i_start: to RUN if both counts are non-zero, otherwise to DONE.
REQ-021 Counts are latched on the i_start edge; later input changes are ignored until the next job.
REQ-022 RUN issues one read per unstalled cycle for in = 0..Ti-1 (inner loop) and out = 0..To-1 (outer loop).
REQ-023 Address rules: nbin_addr = in; nbout_rd_addr = out; sb_addr is a running counter from 0, incremented per read, wrapping mod 2^ADDR_W.
REQ-024 o_acc_first is high exactly when in == 0.
REQ-025 After the read with in == Ti-1 and out == To-1, RUN goes to DRAIN.
REQ-026 A PIPE-deep shift register carries {valid, last, out} for each read.
REQ-027 o_nbout_wr is asserted when the register tail has valid and last set; o_nbout_wr_addr is the tail's out field.
REQ-028 DRAIN goes to DONE when the shift register holds no valid entries.
REQ-029 DONE pulses o_done for one cycle, then returns to IDLE.
REQ-030 While i_stall is high: FSM, counters and shift register hold; o_rd and o_nbout_wr are 0.
REQ-031 Stall applies in RUN and DRAIN; a stall is not a pending event and writes nothing on release.
REQ-032 i_start is ignored unless the FSM is in IDLE.
REQ-033 When i_start and i_stall are high together in IDLE, the start is still accepted.
REQ-034 Per job: exactly Ti*To reads and To writes.
REQ-035 The write for output tile k occurs PIPE unstalled cycles after its last read.

Reset
REQ-036 When rst is high: FSM goes to IDLE and counters, latched counts, address outputs and the shift register clear to 0.
REQ-037 o_busy, o_done, o_rd, o_acc_first and o_nbout_wr are 0 during and immediately after reset.
REQ-038 Reset in mid-job aborts the job: no further reads, no pending writes, no o_done.
REQ-039 rst has priority over i_start and i_stall.

Structure
REQ-040 Shared package nfu_pkg holds the state enum, N, ADDR_W and PIPE defaults.
REQ-041 The pipeline tracker is one sub-module, nfu_wr_tracker: parameterised shift register with a stall input.

Verification
REQ-042 Ti=3, To=2, PIPE=3, no stall:
  - 6 reads; nbin_addr 0,1,2,0,1,2; sb_addr 0..5; acc_first on reads 0 and 3.
  - Writes to addr 0 at cycle 5 and addr 1 at cycle 8 (read 0 = cycle 0); o_done at cycle 9.
REQ-043 Ti=4, To=1, stall held 2 cycles after read 1: reads resume with in=2, write delayed by 2 cycles, exactly 1 write.
REQ-044 i_num_in=0, i_num_out=5: no o_rd, no o_nbout_wr; o_done 2 cycles after start.
REQ-045 Ti=2, To=3, rst asserted after read 3: all strobes 0 next cycle, no write, no o_done; a new start then runs a complete job.
REQ-046 Ti=16, To=17: sb_addr wraps 255 -> 0 at read 256; exactly 17 writes to addresses 0..16.
REQ-047 Second i_start pulsed mid-job: ignored; the counts of the first job are unchanged.
